// File: rtl/fl_checkpoint_ctrl_pkg.sv
// Shared types and helpers for the free-list branch checkpoint manager.
package fl_checkpoint_ctrl_pkg;

  localparam int FL_SIZE      = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int NUM_CKPT     = 4;
  localparam int PREG_W       = $clog2(NUM_PHYS_REG) + 1;
  localparam int CT           = $clog2(NUM_CKPT);
  localparam int TAIL_W       = $clog2(FL_SIZE) + 1;

  typedef logic [PREG_W-1:0]   PHYS_REG;
  typedef logic [CT-1:0]       CKPT_TAG;
  typedef logic [TAIL_W-1:0]   fl_tail_t;
  typedef PHYS_REG [FL_SIZE-1:0] fl_list_t;

  typedef struct packed {
    logic     valid;
    fl_list_t list;
    fl_tail_t tail;
  } ckpt_entry_t;

  localparam fl_tail_t TAIL_FULL = fl_tail_t'(FL_SIZE);

  // Append a freed register at the tail; a full snapshot saturates unchanged.
  function automatic ckpt_entry_t ckpt_append(input ckpt_entry_t e, input logic en,
                                              input PHYS_REG t_old);
    ckpt_entry_t r;
    r = e;
    if (en && (e.tail < TAIL_FULL)) begin
      r.list[e.tail[TAIL_W-2:0]] = {1'b0, t_old[PREG_W-2:0]};
      r.tail                     = e.tail + fl_tail_t'(1);
    end else begin
      r = e;
    end
    return r;
  endfunction

  function automatic logic [CT:0] count_live(input logic [NUM_CKPT-1:0] v);
    logic [CT:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      cnt = cnt + {{CT{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/fl_checkpoint_ctrl_if.sv
// Free-list / dispatch / ROB side of the checkpoint manager.
interface fl_checkpoint_ctrl_if import fl_checkpoint_ctrl_pkg::*; ();

  fl_list_t    fl_list_in;
  fl_tail_t    fl_tail_in;
  logic        dispatch_branch;
  logic        retire_en;
  PHYS_REG     retire_T_old;
  logic        resolve_valid;
  CKPT_TAG     resolve_tag;
  logic        resolve_correct;
  logic        ckpt_full;
  CKPT_TAG     ckpt_tag;
  logic        branch_incorrect;
  fl_list_t    free_check_point;
  fl_tail_t    tail_check_point;
  logic [CT:0] num_live;

  modport master (
    output fl_list_in, fl_tail_in, dispatch_branch, retire_en, retire_T_old,
           resolve_valid, resolve_tag, resolve_correct,
    input  ckpt_full, ckpt_tag, branch_incorrect, free_check_point,
           tail_check_point, num_live
  );

  modport slave (
    input  fl_list_in, fl_tail_in, dispatch_branch, retire_en, retire_T_old,
           resolve_valid, resolve_tag, resolve_correct,
    output ckpt_full, ckpt_tag, branch_incorrect, free_check_point,
           tail_check_point, num_live
  );

endinterface

// File: rtl/fl_checkpoint_ctrl_slot.sv
// One checkpoint slot: load a snapshot, keep appending retired T_olds, clear on resolve.
module fl_ckpt_slot import fl_checkpoint_ctrl_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        load_i,
  input  fl_list_t    load_list_i,
  input  fl_tail_t    load_tail_i,
  input  logic        retire_en_i,
  input  PHYS_REG     retire_t_old_i,
  output ckpt_entry_t entry_o
);

  ckpt_entry_t entry_q;
  ckpt_entry_t entry_d;
  ckpt_entry_t load_s;

  assign load_s = '{valid: 1'b1, list: load_list_i, tail: load_tail_i};

  // A freshly loaded snapshot already includes the retire of its own cycle.
  always_comb begin
    entry_d = entry_q;
    if (clear_i) begin
      entry_d.valid = 1'b0;
    end else if (load_i) begin
      entry_d = ckpt_append(load_s, retire_en_i, retire_t_old_i);
    end else if (entry_q.valid) begin
      entry_d = ckpt_append(entry_q, retire_en_i, retire_t_old_i);
    end else begin
      entry_d = entry_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/fl_checkpoint_ctrl.sv
// Branch checkpoint manager: snapshots the free list per branch and restores it on mispredict.
module fl_checkpoint_ctrl import fl_checkpoint_ctrl_pkg::*; (
  input logic                  clock,
  input logic                  reset,
  fl_checkpoint_ctrl_if.slave  bus
);

  ckpt_entry_t         slot_entry_s [NUM_CKPT];
  logic [NUM_CKPT-1:0] valid_s;
  logic [NUM_CKPT-1:0] clear_s;
  logic [NUM_CKPT-1:0] load_s;
  logic [NUM_CKPT-1:0] valid_next_s;
  CKPT_TAG             alloc_ptr_q;
  CKPT_TAG             alloc_ptr_d;
  CKPT_TAG             dist_alloc_s;
  logic [CT:0]         num_live_q;
  logic                mispredict_s;
  logic                correct_s;
  logic                alloc_s;
  logic                full_s;
  ckpt_entry_t         restore_s;

  for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
    fl_ckpt_slot u_slot (
      .clock          (clock),
      .reset          (reset),
      .clear_i        (clear_s[g]),
      .load_i         (load_s[g]),
      .load_list_i    (bus.fl_list_in),
      .load_tail_i    (bus.fl_tail_in),
      .retire_en_i    (bus.retire_en),
      .retire_t_old_i (bus.retire_T_old),
      .entry_o        (slot_entry_s[g])
    );
    assign valid_s[g] = slot_entry_s[g].valid;
  end

  assign mispredict_s = bus.resolve_valid & ~bus.resolve_correct & valid_s[bus.resolve_tag];
  assign correct_s    = bus.resolve_valid &  bus.resolve_correct & valid_s[bus.resolve_tag];
  assign full_s       = valid_s[alloc_ptr_q];
  assign alloc_s      = bus.dispatch_branch & ~full_s & ~mispredict_s;
  assign dist_alloc_s = alloc_ptr_q - bus.resolve_tag;

  // Squash window runs from the resolving tag up to alloc_ptr-1; distance 0 means a full ring.
  always_comb begin
    CKPT_TAG dist_i;
    clear_s      = '0;
    load_s       = '0;
    valid_next_s = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      dist_i    = CKPT_TAG'(i) - bus.resolve_tag;
      load_s[i] = alloc_s && (alloc_ptr_q == CKPT_TAG'(i));
      if (mispredict_s) begin
        clear_s[i] = (dist_alloc_s == CKPT_TAG'(0)) || (dist_i < dist_alloc_s);
      end else if (correct_s) begin
        clear_s[i] = (bus.resolve_tag == CKPT_TAG'(i));
      end else begin
        clear_s[i] = 1'b0;
      end
      valid_next_s[i] = clear_s[i] ? 1'b0 : (load_s[i] | valid_s[i]);
    end
  end

  // Allocation pointer and live count.
  always_comb begin
    if (mispredict_s) begin
      alloc_ptr_d = bus.resolve_tag;
    end else if (alloc_s) begin
      alloc_ptr_d = alloc_ptr_q + CKPT_TAG'(1);
    end else begin
      alloc_ptr_d = alloc_ptr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alloc_ptr_q <= '0;
      num_live_q  <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      num_live_q  <= count_live(valid_next_s);
    end
  end

  assign restore_s = ckpt_append(slot_entry_s[bus.resolve_tag], bus.retire_en, bus.retire_T_old);

  assign bus.ckpt_full        = full_s;
  assign bus.ckpt_tag         = alloc_ptr_q;
  assign bus.branch_incorrect = mispredict_s & restore_s.valid;
  assign bus.free_check_point = restore_s.list;
  assign bus.tail_check_point = restore_s.tail;
  assign bus.num_live         = num_live_q;

endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
// Directed scoreboard bench for fl_checkpoint_ctrl.
module tb_fl_checkpoint_ctrl;
  import fl_checkpoint_ctrl_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  fl_checkpoint_ctrl_if bus();

  fl_checkpoint_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input string n, input logic [31:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic idle();
    bus.dispatch_branch = 1'b0;
    bus.retire_en       = 1'b0;
    bus.retire_T_old    = '0;
    bus.resolve_valid   = 1'b0;
    bus.resolve_correct = 1'b0;
    bus.resolve_tag     = '0;
  endtask

  task automatic set_list(input int base, input int n, input int tail);
    for (int i = 0; i < FL_SIZE; i++) begin
      bus.fl_list_in[i] = (i < n) ? PHYS_REG'(base + i) : '0;
    end
    bus.fl_tail_in = fl_tail_t'(tail);
  endtask

  task automatic resolve(input int tag, input logic correct);
    bus.resolve_valid   = 1'b1;
    bus.resolve_tag     = CKPT_TAG'(tag);
    bus.resolve_correct = correct;
  endtask

  task automatic chk_state(input int live, input int full, input int tag);
    push("num_live", 32'(live));
    push("ckpt_full", 32'(full));
    push("ckpt_tag", 32'(tag));
    settle();
    pop_chk(32'(bus.num_live));
    pop_chk(32'(bus.ckpt_full));
    pop_chk(32'(bus.ckpt_tag));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    set_list(0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    push("rst_bi", 32'd0);
    chk_state(0, 0, 0);
    pop_chk(32'(bus.branch_incorrect));

    // Full snapshot at tail 32
    set_list(32, 32, 32);
    bus.dispatch_branch = 1'b1;
    push("t1_tag", 32'd0);
    settle();
    pop_chk(32'(bus.ckpt_tag));
    tick();
    idle();
    chk_state(1, 0, 1);
    bus.retire_en    = 1'b1;
    bus.retire_T_old = PHYS_REG'(5);
    tick();
    resolve(0, 1'b0);
    push("sat_bi", 32'd1);
    push("sat_tail", 32'd32);
    push("sat_e0", 32'd32);
    push("sat_e31", 32'd63);
    settle();
    pop_chk(32'(bus.branch_incorrect));
    pop_chk(32'(bus.tail_check_point));
    pop_chk(32'(bus.free_check_point[0]));
    pop_chk(32'(bus.free_check_point[31]));
    tick();
    idle();
    chk_state(0, 0, 0);

    // Snapshot at tail 5 plus two retires, then restore
    set_list(40, 5, 5);
    bus.dispatch_branch = 1'b1;
    tick();
    idle();
    bus.retire_en    = 1'b1;
    bus.retire_T_old = PHYS_REG'(7);
    tick();
    tick();
    idle();
    resolve(0, 1'b0);
    push("t2_bi", 32'd1);
    push("t2_tail", 32'd7);
    push("t2_e0", 32'd40);
    push("t2_e4", 32'd44);
    push("t2_e5", 32'd7);
    push("t2_e6", 32'd7);
    settle();
    pop_chk(32'(bus.branch_incorrect));
    pop_chk(32'(bus.tail_check_point));
    pop_chk(32'(bus.free_check_point[0]));
    pop_chk(32'(bus.free_check_point[4]));
    pop_chk(32'(bus.free_check_point[5]));
    pop_chk(32'(bus.free_check_point[6]));
    tick();
    idle();
    chk_state(0, 0, 0);

    // Fill all slots, overflow dispatch ignored, in-order drain of alloc slot
    for (int i = 0; i < NUM_CKPT; i++) begin
      bus.dispatch_branch = 1'b1;
      push("fill_tag", 32'(i));
      settle();
      pop_chk(32'(bus.ckpt_tag));
      tick();
    end
    idle();
    chk_state(4, 1, 0);
    bus.dispatch_branch = 1'b1;
    tick();
    idle();
    chk_state(4, 1, 0);
    resolve(1, 1'b1);
    push("ok_bi", 32'd0);
    settle();
    pop_chk(32'(bus.branch_incorrect));
    tick();
    idle();
    chk_state(3, 1, 0);
    resolve(0, 1'b1);
    tick();
    idle();
    chk_state(2, 0, 0);
    resolve(2, 1'b1);
    tick();
    resolve(3, 1'b1);
    tick();
    idle();
    chk_state(0, 0, 0);

    // Live 1,2,3 with alloc_ptr 0; mispredict tag 2
    for (int i = 0; i < NUM_CKPT; i++) begin
      bus.dispatch_branch = 1'b1;
      tick();
    end
    idle();
    resolve(0, 1'b1);
    tick();
    idle();
    chk_state(3, 0, 0);
    resolve(2, 1'b0);
    push("t4_bi", 32'd1);
    settle();
    pop_chk(32'(bus.branch_incorrect));
    tick();
    idle();
    chk_state(1, 0, 2);
    resolve(3, 1'b0);
    push("inv_bi", 32'd0);
    settle();
    pop_chk(32'(bus.branch_incorrect));
    tick();
    idle();
    resolve(1, 1'b0);
    push("t4_live1_bi", 32'd1);
    settle();
    pop_chk(32'(bus.branch_incorrect));
    tick();
    idle();
    chk_state(0, 0, 1);

    // Mispredict with same-cycle dispatch and retire at tail 31
    set_list(10, 31, 31);
    bus.dispatch_branch = 1'b1;
    tick();
    idle();
    bus.dispatch_branch = 1'b1;
    bus.retire_en       = 1'b1;
    bus.retire_T_old    = PHYS_REG'(9);
    resolve(1, 1'b0);
    push("t5_bi", 32'd1);
    push("t5_tail", 32'd32);
    push("t5_e31", 32'd9);
    push("t5_e30", 32'd40);
    push("t5_e0", 32'd10);
    settle();
    pop_chk(32'(bus.branch_incorrect));
    pop_chk(32'(bus.tail_check_point));
    pop_chk(32'(bus.free_check_point[31]));
    pop_chk(32'(bus.free_check_point[30]));
    pop_chk(32'(bus.free_check_point[0]));
    tick();
    idle();
    chk_state(0, 0, 1);

    // Reset with live checkpoints
    bus.dispatch_branch = 1'b1;
    tick();
    tick();
    idle();
    chk_state(2, 0, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_state(0, 0, 0);

    if (sb.size() != 0) begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
